pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed-field stage registers between decode/execute and later stages.
- Carries an opaque data payload, a control bundle and a nop marker through a valid/ready handshake.
- Adds a two-entry skid buffer so the upstream ready has no combinational path from downstream, plus per-stage stall, flush and nop-squash of control side effects.
- Sits between any two pipeline stages; one instance per boundary.

Parameters:
- DATA_W, 64, payload width (register data, immediates, PC packed by the instantiating stage).
- CTRL_W, 16, control bundle width (RegWrite, MemWrite, halt, etc. packed by the instantiating stage).
- CTRL_NOP, {CTRL_W{1'b0}}, control value presented in place of the stored control when the head entry is a nop.
- SKID_EN, 1, 1 = two-entry skid buffer with registered-state in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: low clears state immediately.
- stall  in  1  hold: no accept, no emit, contents frozen.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- in_nop  in  1  upstream entry is a bubble.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control, or CTRL_NOP when the head is a nop.
- out_nop  out  1  head is a nop (qualified by out_valid).
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Handshake rules:
  - Accept occurs when in_valid & in_ready. Emit occurs when out_valid & out_ready.
  - Entries leave in FIFO order. Latency is 1 cycle from accept to out_valid when the stage is empty; there is no combinational data bypass.
- State: occ ∈ {EMPTY, ONE, TWO}. Head entry is in the main register; the skid register holds the second entry.
- Reset (rst low):
  - occ=EMPTY, so out_valid=0, out_nop=0 and occupancy=0.
  - Payload registers are not required to reset; out_data is don't-care while out_valid=0.
  - out_ctrl=CTRL_NOP while out_valid=0.
  - An accept attempted while rst is low is ignored.
- in_ready:
  - SKID_EN=1: in_ready = ~stall & (occ!=TWO). It is decoded from state only; there is no path from out_ready.
  - SKID_EN=0: capacity 1, in_ready = ~stall & (occ==EMPTY | out_ready). This combinational path is permitted and must be documented at the instantiation.
- out_valid = (occ!=EMPTY) & ~stall. While stalled, the stage presents a bubble downstream but keeps its contents.
- Transitions (no stall, no flush):
  - EMPTY + accept -> ONE; the main register loads the input.
  - ONE + accept + emit -> ONE; the main register loads the input.
  - ONE + accept only -> TWO (SKID_EN=1); the skid register loads the input.
  - ONE + emit only -> EMPTY.
  - TWO + emit -> ONE; skid moves to main. No accept is possible in TWO.
  - Otherwise the state holds.
- Stall: no accept and no emit, so all registers and occ hold. A stall asserted mid-handshake cancels that cycle's transfer on both sides.
- Flush:
  - Next edge sets occ=EMPTY.
  - Flush has priority over a simultaneous accept: the input is dropped even though in_ready was high. Upstream must treat a flush cycle as non-accepting.
  - Flush has priority over stall.
  - A simultaneous emit still counts as completed downstream; the entry is not replayed.
- Nop:
  - The nop flag is stored per entry.
  - When the head is a nop, out_ctrl=CTRL_NOP regardless of the stored ctrl, out_nop=1, and out_valid is still driven. The bubble occupies a slot and is consumed normally.
  - out_data passes through unmodified.
- occupancy mirrors occ encoding: 0, 1 or 2.

Decomposition:
- Package pipe_pkg holds:
  - occ_t enum (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - localparam for entry width (DATA_W+CTRL_W+1) computed in the module.
- Sub-module pipe_entry: an enable-loaded register of {nop, ctrl, data} with async active-low reset on the nop bit only.
  - Instantiated as main and skid. The skid instance is generated only when SKID_EN=1.
- The top module contains the occ FSM, the in_ready/out_valid decode and the nop/ctrl output mux.

Test Plan:
- Reset then single entry, SKID_EN=1:
  - Stimulus: rst low 2 cycles, then accept data=0x1234, ctrl=0x00FF, nop=0.
  - Required: out_valid=1 the next cycle, out_data=0x1234, out_ctrl=0x00FF, occupancy=1.
- Back-pressure fill:
  - Stimulus: out_ready=0, push A then B.
  - Required: occupancy=2 and in_ready=0. Then raise out_ready: A emitted, then B, in order; in_ready returns to 1 the cycle after A leaves.
- Streaming throughput:
  - Stimulus: in_valid=out_ready=1 for 20 cycles with incrementing data.
  - Required: one emit per cycle after 1 cycle of latency, data sequence preserved, occupancy stays 1.
- Stall:
  - Stimulus: assert stall with occupancy=2 for 3 cycles, while in_valid=1.
  - Required: in_ready=0, out_valid=0, occupancy=2 held. After release, A then B emitted unchanged.
- Flush with concurrent accept:
  - Stimulus: occupancy=1; in the same cycle flush=1 and in_valid=1 with data=0xBEEF.
  - Required: the next cycle occupancy=0 and out_valid=0; 0xBEEF never appears at the output.
- Nop squash:
  - Stimulus: push nop=1, ctrl=0xFFFF with CTRL_NOP=0.
  - Required: out_valid=1, out_nop=1, out_ctrl=0x0000, out_data passed through.
  - Repeat with SKID_EN=0: in_ready follows out_ready combinationally when occupancy=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy state encoding
// and the packed {nop, ctrl, data} entry width helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    function automatic int entry_width(input int dataW, input int ctrlW);
        return dataW + ctrlW + 1;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One stage-register slot holding {nop, ctrl, data}; only the nop bit is reset
// so an empty slot can never be mistaken for a live bubble.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     load_i,
    input  logic [entry_width(DATA_W, CTRL_W)-1:0]   entry_i,
    output logic [entry_width(DATA_W, CTRL_W)-1:0]   entry_o
);

    localparam int ENTRY_W = entry_width(DATA_W, CTRL_W);

    logic                 nop_q;
    logic [ENTRY_W-2:0]   payload_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nop_q <= 1'b0;
        end else if (load_i) begin
            nop_q <= entry_i[ENTRY_W-1];
        end
    end

    // Payload is don't-care while the slot is empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            payload_q <= entry_i[ENTRY_W-2:0];
        end
    end

    assign entry_o = {nop_q, payload_q};

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// per-stage stall, flush and nop squashing of the control bundle.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
    parameter bit                SKID_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_nop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_nop,
    output logic [1:0]        occupancy
);

    localparam int ENTRY_W = entry_width(DATA_W, CTRL_W);

    occ_t               occ_q;
    logic               accept;
    logic               emit;
    logic               mainLoad;
    logic               skidLoad;
    logic [ENTRY_W-1:0] inEntry;
    logic [ENTRY_W-1:0] mainEntryIn;
    logic [ENTRY_W-1:0] mainEntry;
    logic [ENTRY_W-1:0] skidEntry;
    logic               headNop;
    logic [CTRL_W-1:0]  headCtrl;

    assign inEntry = {in_nop, in_ctrl, in_data};

    // With the skid buffer, in_ready depends on state only; without it the
    // stage can refill in the cycle it drains, at the cost of a path from out_ready.
    generate
        if (SKID_EN) begin : g_readySkid
            assign in_ready = ~stall & (occ_q != TWO);
        end else begin : g_readyFlow
            assign in_ready = ~stall & ((occ_q == EMPTY) | out_ready);
        end
    endgenerate

    assign out_valid = (occ_q != EMPTY) & ~stall;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        mainLoad = 1'b0;
        skidLoad = 1'b0;
        if (!flush) begin
            case (occ_q)
                EMPTY: mainLoad = accept;
                ONE: begin
                    mainLoad = accept & emit;
                    skidLoad = SKID_EN & accept & ~emit;
                end
                TWO:     mainLoad = emit;
                default: mainLoad = 1'b0;
            endcase
        end
    end

    // When draining from TWO the head refills from the skid slot, not the input.
    assign mainEntryIn = (occ_q == TWO) ? skidEntry : inEntry;

    // Flush wins over stall and any simultaneous accept; an emit in the same
    // cycle is still considered delivered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= EMPTY;
        end else if (flush) begin
            occ_q <= EMPTY;
        end else begin
            case (occ_q)
                EMPTY: begin
                    if (accept) occ_q <= ONE;
                end
                ONE: begin
                    if (skidLoad)             occ_q <= TWO;
                    else if (emit && !accept) occ_q <= EMPTY;
                end
                TWO: begin
                    if (emit) occ_q <= ONE;
                end
                default: occ_q <= EMPTY;
            endcase
        end
    end

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (mainLoad),
        .entry_i (mainEntryIn),
        .entry_o (mainEntry)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_entry #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load_i  (skidLoad),
                .entry_i (inEntry),
                .entry_o (skidEntry)
            );
        end else begin : g_noSkid
            assign skidEntry = '0;
        end
    endgenerate

    // A nop head still occupies a slot and is consumed, but shows no side effects.
    assign headNop   = mainEntry[ENTRY_W-1];
    assign headCtrl  = mainEntry[DATA_W +: CTRL_W];
    assign out_data  = mainEntry[DATA_W-1:0];
    assign out_nop   = out_valid & headNop;
    assign out_ctrl  = (out_valid & ~headNop) ? headCtrl : CTRL_NOP;
    assign occupancy = occ_q;

endmodule
